axi_lite_sram: RTL and testbench

- AXI-Lite slave memory sitting directly downstream of the AXI-Lite arbiter's master port. It is the target of the merged IFU/LSU traffic.
- Word-organised SRAM model with byte strobes and an address range check.
- Each accepted transaction waits a programmable delay before responding, so upstream handshakes are exercised under latency.

---
 rtl/axi_lite_sram_pkg.sv | 19 +
 rtl/axi_lite_delay_lfsr.sv | 20 ++
 rtl/axi_lite_sram.sv | 163 ++++++++++++++++
 tb/tb_axi_lite_sram.sv | 397 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_lite_sram_pkg.sv
// Shared types and constants for the AXI-Lite SRAM slave.
package axi_lite_sram_pkg;

  localparam int unsigned CPU_WIDTH = 32;
  localparam int unsigned STRB_W    = CPU_WIDTH / 8;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {
    IDLE,
    W_COLLECT,
    R_DELAY,
    R_RESP,
    W_DELAY,
    W_RESP
  } sram_state_e;

endpackage

// File: rtl/axi_lite_delay_lfsr.sv
// 8-bit Fibonacci LFSR (taps 8,6,5,4) used to randomise response latency.
// Built only when AXI_SRAM_RAND_DELAY_EN is defined.
`ifdef AXI_SRAM_RAND_DELAY_EN
module axi_lite_delay_lfsr (
  input  logic       i_clk,
  input  logic       i_rst,
  output logic [7:0] o_lfsr
);

  logic feedback;

  assign feedback = o_lfsr[7] ^ o_lfsr[5] ^ o_lfsr[4] ^ o_lfsr[3];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) o_lfsr <= 8'h5A;
    else       o_lfsr <= {o_lfsr[6:0], feedback};
  end

endmodule
`endif

// File: rtl/axi_lite_sram.sv
// AXI-Lite word SRAM slave with byte strobes, range check and response delay.
// Define AXI_SRAM_RAND_DELAY_EN to add an LFSR-driven random delay component.
module axi_lite_sram
  import axi_lite_sram_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000,
  parameter int unsigned MEM_WORDS = 1024,
  parameter int unsigned LAT_MIN   = 0,
  parameter logic [7:0]  LAT_MASK  = 8'h07
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [CPU_WIDTH-1:0] s_awaddr,
  input  logic                 s_awvalid,
  output logic                 s_awready,
  input  logic [CPU_WIDTH-1:0] s_wdata,
  input  logic [STRB_W-1:0]    s_wstrb,
  input  logic                 s_wvalid,
  output logic                 s_wready,
  output logic [1:0]           s_bresp,
  output logic                 s_bvalid,
  input  logic                 s_bready,
  input  logic [CPU_WIDTH-1:0] s_araddr,
  input  logic                 s_arvalid,
  output logic                 s_arready,
  output logic [CPU_WIDTH-1:0] s_rdata,
  output logic [1:0]           s_rresp,
  output logic                 s_rvalid,
  input  logic                 s_rready
);

  localparam int unsigned IDX_W = $clog2(MEM_WORDS);
  localparam logic [32:0] SPAN  = 33'(MEM_WORDS) << 2;

  sram_state_e state_q, state_d;

  logic [CPU_WIDTH-1:0] mem [MEM_WORDS];
  logic [CPU_WIDTH-1:0] addr_q, wdata_q, off;
  logic [STRB_W-1:0]    wstrb_q;
  logic                 aw_got, w_got;
  logic [7:0]           cnt_q, delay, lfsr;
  logic                 hit, ar_hs, aw_hs, w_hs, cnt_zero;
  logic [IDX_W-1:0]     idx;
  logic                 unused_off;

`ifdef AXI_SRAM_RAND_DELAY_EN
  axi_lite_delay_lfsr u_lfsr (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .o_lfsr (lfsr)
  );
`else
  assign lfsr = '0;
`endif

  assign delay = 8'(LAT_MIN) + (lfsr & LAT_MASK);

  // Unsigned offset compare covers both range bounds in one test.
  assign off        = addr_q - BASE_ADDR;
  assign hit        = {1'b0, off} < SPAN;
  assign idx        = off[IDX_W+1:2];
  assign unused_off = ^{off[1:0], off[CPU_WIDTH-1:IDX_W+2]};
  assign cnt_zero   = (cnt_q == '0);

  assign ar_hs = s_arvalid && s_arready;
  assign aw_hs = s_awvalid && s_awready;
  assign w_hs  = s_wvalid  && s_wready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    s_arready = 1'b0;
    s_awready = 1'b0;
    s_wready  = 1'b0;
    unique case (state_q)
      IDLE: begin
        s_arready = 1'b1;
        s_awready = !s_arvalid;
        s_wready  = !s_arvalid;
        if (s_arvalid)                    state_d = R_DELAY;
        else if (s_awvalid && s_wvalid)   state_d = W_DELAY;
        else if (s_awvalid || s_wvalid)   state_d = W_COLLECT;
      end
      W_COLLECT: begin
        s_awready = !aw_got;
        s_wready  = !w_got;
        if ((aw_got || s_awvalid) && (w_got || s_wvalid)) state_d = W_DELAY;
      end
      R_DELAY: if (cnt_zero) state_d = R_RESP;
      W_DELAY: if (cnt_zero) state_d = W_RESP;
      R_RESP:  if (s_rready) state_d = IDLE;
      W_RESP:  if (s_bready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // Readys derive from state, so hold them low while reset is asserted.
    if (i_rst) begin
      s_arready = 1'b0;
      s_awready = 1'b0;
      s_wready  = 1'b0;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      addr_q   <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      aw_got   <= 1'b0;
      w_got    <= 1'b0;
      cnt_q    <= '0;
      s_rdata  <= '0;
      s_rresp  <= '0;
      s_rvalid <= 1'b0;
      s_bresp  <= '0;
      s_bvalid <= 1'b0;
    end else begin
      if (ar_hs) begin
        addr_q <= s_araddr;
        cnt_q  <= delay;
      end
      if (aw_hs) begin
        addr_q <= s_awaddr;
        aw_got <= 1'b1;
      end
      if (w_hs) begin
        wdata_q <= s_wdata;
        wstrb_q <= s_wstrb;
        w_got   <= 1'b1;
      end
      if (state_d == W_DELAY && state_q != W_DELAY) begin
        cnt_q  <= delay;
        aw_got <= 1'b0;
        w_got  <= 1'b0;
      end
      if ((state_q == R_DELAY || state_q == W_DELAY) && !cnt_zero)
        cnt_q <= cnt_q - 8'd1;
      if (state_q == R_DELAY && cnt_zero) begin
        s_rdata  <= hit ? mem[idx] : '0;
        s_rresp  <= hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        s_rvalid <= 1'b1;
      end
      if (state_q == R_RESP && s_rready) s_rvalid <= 1'b0;
      if (state_q == W_DELAY && cnt_zero) begin
        s_bresp  <= hit ? AXI_RESP_OKAY : AXI_RESP_SLVERR;
        s_bvalid <= 1'b1;
      end
      if (state_q == W_RESP && s_bready) s_bvalid <= 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (state_q == W_DELAY && cnt_zero && hit) begin
      for (int unsigned b = 0; b < STRB_W; b++) begin
        if (wstrb_q[b]) mem[idx][8*b +: 8] <= wdata_q[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram.sv
// Self-checking bench for axi_lite_sram against a behavioural word-array model.
module tb_axi_lite_sram;

  localparam logic [31:0] BASE      = 32'h8000_0000;
  localparam int          MEM_WORDS = 1024;
  localparam int          LAT_MIN   = 2;
`ifdef AXI_SRAM_RAND_DELAY_EN
  localparam int LAT_LO = LAT_MIN + 1;
  localparam int LAT_HI = LAT_MIN + 1 + 7;
`else
  localparam int LAT_LO = LAT_MIN + 1;
  localparam int LAT_HI = LAT_MIN + 1;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] awaddr = '0, wdata = '0, araddr = '0, rdata;
  logic [3:0]  wstrb = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, arvalid = 1'b0, bready = 1'b0, rready = 1'b0;
  logic        awready, wready, arready, bvalid, rvalid;
  logic [1:0]  bresp, rresp;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] ref_mem [MEM_WORDS];

  always #5 clk = ~clk;

  axi_lite_sram #(
    .BASE_ADDR (BASE),
    .MEM_WORDS (MEM_WORDS),
    .LAT_MIN   (LAT_MIN),
    .LAT_MASK  (8'h07)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .s_awaddr  (awaddr),
    .s_awvalid (awvalid),
    .s_awready (awready),
    .s_wdata   (wdata),
    .s_wstrb   (wstrb),
    .s_wvalid  (wvalid),
    .s_wready  (wready),
    .s_bresp   (bresp),
    .s_bvalid  (bvalid),
    .s_bready  (bready),
    .s_araddr  (araddr),
    .s_arvalid (arvalid),
    .s_arready (arready),
    .s_rdata   (rdata),
    .s_rresp   (rresp),
    .s_rvalid  (rvalid),
    .s_rready  (rready)
  );

  function automatic bit in_range(input logic [31:0] a);
    return (longint'(a) >= longint'(BASE)) && (longint'(a) < longint'(BASE) + 4 * MEM_WORDS);
  endfunction

  function automatic int word_of(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'(o >> 2) % MEM_WORDS;
  endfunction

  function automatic void model_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    if (in_range(a))
      for (int b = 0; b < 4; b++)
        if (s[b]) ref_mem[word_of(a)][8*b +: 8] = d[8*b +: 8];
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] a);
    return in_range(a) ? ref_mem[word_of(a)] : 32'h0;
  endfunction

  function automatic logic [1:0] model_resp(input logic [31:0] a);
    return in_range(a) ? 2'b00 : 2'b10;
  endfunction

  // Transaction drivers; all start and end at posedge+1.
  task automatic do_read(input logic [31:0] a, output logic [31:0] d, output logic [1:0] r,
                         output int lat);
    bit hs;
    int n = 0;
    araddr  = a;
    arvalid = 1'b1;
    d = '0; r = '0; lat = -1;
    forever begin
      #1 hs = arready;
      @(posedge clk); #1;
      if (hs) break;
      if (++n > 60) begin
        vectors++; miscompares++;
        $display("FAIL read_ar_timeout addr=%h", a);
        arvalid = 1'b0;
        return;
      end
    end
    arvalid = 1'b0;
    lat = 0;
    while (!rvalid) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 60) begin
        vectors++; miscompares++;
        $display("FAIL read_rvalid_timeout addr=%h", a);
        lat = -1;
        return;
      end
    end
    d = rdata;
    r = rresp;
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_at, input int w_at, output logic [1:0] r,
                          output int lat, output bit ready_ok);
    bit aw_done = 0, w_done = 0, aw_hs, w_hs;
    int c = 0;
    awaddr = a; wdata = d; wstrb = s;
    ready_ok = 1'b1;
    r = '0; lat = -1;
    while (!(aw_done && w_done)) begin
      awvalid = !aw_done && (c >= aw_at);
      wvalid  = !w_done && (c >= w_at);
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if ((aw_done && awready) || (w_done && wready)) ready_ok = 1'b0;
      @(posedge clk); #1;
      aw_done |= aw_hs;
      w_done  |= w_hs;
      if (++c > 80) begin
        vectors++; miscompares++;
        $display("FAIL write_req_timeout addr=%h", a);
        awvalid = 1'b0; wvalid = 1'b0;
        return;
      end
    end
    awvalid = 1'b0;
    wvalid  = 1'b0;
    lat = 0;
    while (!bvalid) begin
      @(posedge clk); #1;
      lat++;
      if (lat > 60) begin
        vectors++; miscompares++;
        $display("FAIL write_bvalid_timeout addr=%h", a);
        lat = -1;
        return;
      end
    end
    r = bresp;
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    vectors++;
    if ({arready, awready, wready, rvalid, bvalid, bresp, rresp, rdata} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs got ar=%b aw=%b w=%b rv=%b bv=%b rdata=%h exp all 0",
               arready, awready, wready, rvalid, bvalid, rdata);
    end
    rst = 1'b0;
    #1;
    vectors++;
    if (arready !== 1'b1) begin
      miscompares++;
      $display("FAIL idle_arready got %b exp 1", arready);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    do_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 0, 0, r, lat, ok);
    model_write(32'h8000_0010, 32'hDEAD_BEEF, 4'hF);
    vectors++;
    if (r !== 2'b00 || lat < LAT_LO || lat > LAT_HI) begin
      miscompares++; $display("FAIL basic_write bresp=%b lat=%0d exp 00 lat %0d..%0d", r, lat, LAT_LO, LAT_HI);
    end
    do_read(32'h8000_0010, d, r, lat);
    vectors++;
    if (d !== 32'hDEAD_BEEF || r !== 2'b00 || lat < LAT_LO || lat > LAT_HI) begin
      miscompares++; $display("FAIL basic_read rdata=%h rresp=%b lat=%0d exp DEADBEEF 00 %0d..%0d", d, r, lat, LAT_LO, LAT_HI);
    end
    do_write(32'h8000_0010, 32'h0000_1122, 4'b0011, 0, 0, r, lat, ok);
    model_write(32'h8000_0010, 32'h0000_1122, 4'b0011);
    do_read(32'h8000_0010, d, r, lat);
    vectors++;
    if (d !== 32'hDEAD_1122 || d !== model_read(32'h8000_0010)) begin
      miscompares++; $display("FAIL strobe_read rdata=%h exp DEAD1122", d);
    end
    do_write(32'h8000_0012, 32'hFFFF_FFFF, 4'h0, 0, 0, r, lat, ok);
    do_read(32'h8000_0010, d, r, lat);
    vectors++;
    if (r !== 2'b00 || d !== 32'hDEAD_1122) begin
      miscompares++; $display("FAIL zero_strobe rdata=%h resp=%b exp DEAD1122 00", d, r);
    end
  endtask

  task automatic test_aw_before_w();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    do_write(32'h8000_0040, 32'h0BAD_F00D, 4'hF, 0, 4, r, lat, ok);
    model_write(32'h8000_0040, 32'h0BAD_F00D, 4'hF);
    vectors++;
    if (!ok || r !== 2'b00 || lat < LAT_LO || lat > LAT_HI) begin
      miscompares++; $display("FAIL aw_first ready_ok=%b bresp=%b lat=%0d exp 1 00 %0d..%0d", ok, r, lat, LAT_LO, LAT_HI);
    end
    do_write(32'h8000_0044, 32'h1357_9BDF, 4'hF, 3, 0, r, lat, ok);
    model_write(32'h8000_0044, 32'h1357_9BDF, 4'hF);
    vectors++;
    if (!ok || r !== 2'b00 || lat < LAT_LO || lat > LAT_HI) begin
      miscompares++; $display("FAIL w_first ready_ok=%b bresp=%b lat=%0d", ok, r, lat);
    end
    do_read(32'h8000_0040, d, r, lat);
    vectors++;
    if (d !== model_read(32'h8000_0040)) begin
      miscompares++; $display("FAIL aw_first_data got %h exp %h", d, model_read(32'h8000_0040));
    end
  endtask

  task automatic test_out_of_range();
    logic [31:0] d; logic [1:0] r; int lat; bit ok;
    do_write(32'h8000_0000, 32'hA5A5_5A5A, 4'hF, 0, 0, r, lat, ok);
    model_write(32'h8000_0000, 32'hA5A5_5A5A, 4'hF);
    do_read(32'h7FFF_FFFC, d, r, lat);
    vectors++;
    if (r !== 2'b10 || d !== 32'h0) begin
      miscompares++; $display("FAIL oor_read rresp=%b rdata=%h exp 10 0", r, d);
    end
    do_write(32'h8000_1000, 32'h1111_2222, 4'hF, 0, 0, r, lat, ok);
    vectors++;
    if (r !== 2'b10) begin
      miscompares++; $display("FAIL oor_write bresp=%b exp 10", r);
    end
    do_read(32'h8000_0000, d, r, lat);
    vectors++;
    if (d !== 32'hA5A5_5A5A || r !== 2'b00) begin
      miscompares++; $display("FAIL oor_unchanged rdata=%h resp=%b exp A5A55A5A 00", d, r);
    end
    do_write(32'h8000_0FFC, 32'h7777_8888, 4'hF, 0, 0, r, lat, ok);
    model_write(32'h8000_0FFC, 32'h7777_8888, 4'hF);
    do_read(32'h8000_0FFC, d, r, lat);
    vectors++;
    if (d !== 32'h7777_8888 || r !== 2'b00) begin
      miscompares++; $display("FAIL top_word rdata=%h resp=%b exp 77778888 00", d, r);
    end
    do_read(32'h8000_1000, d, r, lat);
    vectors++;
    if (d !== 32'h0 || r !== 2'b10) begin
      miscompares++; $display("FAIL past_top rdata=%h resp=%b exp 0 10", d, r);
    end
  endtask

  task automatic test_ar_aw_collision();
    logic [31:0] d, held; logic [1:0] r; int lat, n; bit ok, stable;
    do_write(32'h8000_0020, 32'h1234_5678, 4'hF, 0, 0, r, lat, ok);
    model_write(32'h8000_0020, 32'h1234_5678, 4'hF);
    araddr = 32'h8000_0020; arvalid = 1'b1;
    awaddr = 32'h8000_0020; wdata = 32'hCAFE_F00D; wstrb = 4'hF; awvalid = 1'b1; wvalid = 1'b1;
    #1;
    vectors++;
    if (arready !== 1'b1 || awready !== 1'b0 || wready !== 1'b0) begin
      miscompares++; $display("FAIL collision_ready ar=%b aw=%b w=%b exp 1 0 0", arready, awready, wready);
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    n = 0;
    while (!rvalid && n < 60) begin @(posedge clk); #1; n++; end
    held = rdata;
    vectors++;
    if (!rvalid || held !== 32'h1234_5678 || n < LAT_LO || n > LAT_HI) begin
      miscompares++; $display("FAIL collision_read rvalid=%b rdata=%h lat=%0d exp 1 12345678", rvalid, held, n);
    end
    stable = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
      if (rvalid !== 1'b1 || rdata !== held || awready !== 1'b0) stable = 1'b0;
    end
    vectors++;
    if (!stable) begin
      miscompares++; $display("FAIL rresp_hold rvalid=%b rdata=%h exp 1 %h", rvalid, rdata, held);
    end
    rready = 1'b1;
    @(posedge clk); #1;
    rready = 1'b0;
    vectors++;
    if (awready !== 1'b1 || wready !== 1'b1 || rvalid !== 1'b0) begin
      miscompares++; $display("FAIL collision_idle aw=%b w=%b rv=%b exp 1 1 0", awready, wready, rvalid);
    end
    @(posedge clk); #1;
    awvalid = 1'b0; wvalid = 1'b0;
    model_write(32'h8000_0020, 32'hCAFE_F00D, 4'hF);
    n = 0;
    while (!bvalid && n < 60) begin @(posedge clk); #1; n++; end
    vectors++;
    if (!bvalid || bresp !== 2'b00 || n < LAT_LO || n > LAT_HI) begin
      miscompares++; $display("FAIL collision_write bvalid=%b bresp=%b lat=%0d", bvalid, bresp, n);
    end
    bready = 1'b1;
    @(posedge clk); #1;
    bready = 1'b0;
    do_read(32'h8000_0020, d, r, lat);
    vectors++;
    if (d !== model_read(32'h8000_0020)) begin
      miscompares++; $display("FAIL collision_data got %h exp %h", d, model_read(32'h8000_0020));
    end
  endtask

  task automatic test_reset_mid_read();
    logic [31:0] d; logic [1:0] r; int lat; bit ok, seen;
    do_write(32'h8000_0080, 32'h600D_CAFE, 4'hF, 0, 0, r, lat, ok);
    model_write(32'h8000_0080, 32'h600D_CAFE, 4'hF);
    araddr = 32'h8000_0080; arvalid = 1'b1;
    @(posedge clk); #1;
    arvalid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    vectors++;
    if ({arready, awready, wready, rvalid, bvalid} !== 5'b0) begin
      miscompares++; $display("FAIL mid_reset ar=%b aw=%b w=%b rv=%b bv=%b exp 0", arready, awready, wready, rvalid, bvalid);
    end
    @(posedge clk); #1;
    rst = 1'b0;
    seen = 1'b0;
    repeat (8) begin @(posedge clk); #1; if (rvalid) seen = 1'b1; end
    vectors++;
    if (seen) begin
      miscompares++; $display("FAIL abandoned_read rvalid seen=1 exp 0");
    end
    do_read(32'h8000_0080, d, r, lat);
    vectors++;
    if (d !== 32'h600D_CAFE || r !== 2'b00) begin
      miscompares++; $display("FAIL mem_retained rdata=%h resp=%b exp 600DCAFE 00", d, r);
    end
  endtask

  task automatic test_random();
    logic [31:0] addrs [8];
    logic [31:0] a, d, v; logic [1:0] r; logic [3:0] s; int lat; bit ok;
    for (int i = 0; i < 8; i++) begin
      addrs[i] = BASE + 4 * $urandom_range(0, MEM_WORDS - 1);
      v = $urandom;
      do_write(addrs[i], v, 4'hF, 0, 0, r, lat, ok);
      model_write(addrs[i], v, 4'hF);
    end
    for (int it = 0; it < 100; it++) begin
      case ($urandom_range(0, 9))
        8:       a = BASE - 4 * $urandom_range(1, 100);
        9:       a = BASE + 4 * MEM_WORDS + 4 * $urandom_range(0, 100);
        default: a = addrs[$urandom_range(0, 7)] | 32'($urandom_range(0, 3));
      endcase
      if ($urandom_range(0, 1) == 0) begin
        do_read(a, d, r, lat);
        vectors++;
        if (d !== model_read(a) || r !== model_resp(a) || lat < LAT_LO || lat > LAT_HI) begin
          miscompares++;
          $display("FAIL rand_read addr=%h rdata=%h resp=%b lat=%0d exp %h %b %0d..%0d",
                   a, d, r, lat, model_read(a), model_resp(a), LAT_LO, LAT_HI);
        end
      end else begin
        v = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, v, s, $urandom_range(0, 3), $urandom_range(0, 3), r, lat, ok);
        model_write(a, v, s);
        vectors++;
        if (r !== model_resp(a) || !ok || lat < LAT_LO || lat > LAT_HI) begin
          miscompares++;
          $display("FAIL rand_write addr=%h bresp=%b ready_ok=%b lat=%0d exp %b", a, r, ok, lat, model_resp(a));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_aw_before_w();
    test_out_of_range();
    test_ar_aw_collision();
    test_reset_mid_read();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
